// File: rtl/program_loader.sv
// Streams host (address, data) byte pairs into the CPU RAM over the shared bus, holding the core off meanwhile.
// Each pair costs one MAR address load, one MAR data load and one RAM write cycle; all outputs are registered.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RAM_BYTES = 16,
  parameter logic [DATA_W-1:0] END_MARK = 8'hFF,
  localparam int CNT_W = $clog2(RAM_BYTES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_en_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] bus_out_o,
  output logic              bus_oe_o,
  output logic              n_load_addr_o,
  output logic              n_load_data_o,
  output logic              ram_we_o,
  output logic              cpu_hold_o,
  output logic [CNT_W-1:0]  load_count_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WR_ADDR,
    WR_DATA,
    WR_MEM,
    FINISH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAM_BYTES);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                in_ready_q;
  logic [DATA_W-1:0]   bus_out_q;
  logic                bus_oe_q;
  logic                n_load_addr_q;
  logic                n_load_data_q;
  logic                ram_we_q;
  logic                cpu_hold_q;
  logic [CNT_W-1:0]    load_count_q;
  logic                done_q;
  logic                err_q;

  logic xfer;
  assign xfer = in_valid_i & in_ready_q;

  // Outputs are loaded for the state being entered, so each one is glitch-free and aligned with state_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      in_ready_q    <= 1'b0;
      bus_out_q     <= '0;
      bus_oe_q      <= 1'b0;
      n_load_addr_q <= 1'b1;
      n_load_data_q <= 1'b1;
      ram_we_q      <= 1'b0;
      cpu_hold_q    <= 1'b0;
      load_count_q  <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (prog_en_i) begin
            state_q      <= GET_ADDR;
            in_ready_q   <= 1'b1;
            cpu_hold_q   <= 1'b1;
            load_count_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
          end
        end
        GET_ADDR: begin
          if (!prog_en_i) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
          end else if (xfer) begin
            if (in_data_i == END_MARK) begin
              state_q    <= FINISH;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end else if (in_data_i[DATA_W-1:ADDR_W] != '0) begin
              err_q <= 1'b1;
            end else begin
              addr_q  <= in_data_i[ADDR_W-1:0];
              state_q <= GET_DATA;
            end
          end
        end
        GET_DATA: begin
          if (!prog_en_i) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
          end else if (xfer) begin
            data_q        <= in_data_i;
            state_q       <= WR_ADDR;
            in_ready_q    <= 1'b0;
            bus_oe_q      <= 1'b1;
            bus_out_q     <= {{(DATA_W-ADDR_W){1'b0}}, addr_q};
            n_load_addr_q <= 1'b0;
          end
        end
        WR_ADDR: begin
          state_q       <= WR_DATA;
          bus_out_q     <= data_q;
          n_load_addr_q <= 1'b1;
          n_load_data_q <= 1'b0;
        end
        WR_DATA: begin
          state_q       <= WR_MEM;
          bus_oe_q      <= 1'b0;
          bus_out_q     <= '0;
          n_load_data_q <= 1'b1;
          ram_we_q      <= 1'b1;
          if (load_count_q != CNT_MAX) load_count_q <= load_count_q + 1'b1;
        end
        WR_MEM: begin
          ram_we_q <= 1'b0;
          if (prog_en_i) begin
            state_q    <= GET_ADDR;
            in_ready_q <= 1'b1;
          end else begin
            state_q    <= IDLE;
            cpu_hold_q <= 1'b0;
          end
        end
        FINISH: begin
          if (!prog_en_i) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign bus_out_o     = bus_out_q;
  assign bus_oe_o      = bus_oe_q;
  assign n_load_addr_o = n_load_addr_q;
  assign n_load_data_o = n_load_data_q;
  assign ram_we_o      = ram_we_q;
  assign cpu_hold_o    = cpu_hold_q;
  assign load_count_o  = load_count_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Random and directed load sessions; a monitor replays bus strobes into a shadow RAM and scores them against a queue.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_en = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready_o, bus_oe_o, n_load_addr_o, n_load_data_o, ram_we_o, cpu_hold_o, done_o, err_o;
  logic [7:0] bus_out_o;
  logic [4:0] load_count_o;

  program_loader dut (
    .clk_i(clk), .rst_i(rst), .prog_en_i(prog_en), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready_o), .bus_out_o(bus_out_o), .bus_oe_o(bus_oe_o),
    .n_load_addr_o(n_load_addr_o), .n_load_data_o(n_load_data_o), .ram_we_o(ram_we_o),
    .cpu_hold_o(cpu_hold_o), .load_count_o(load_count_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int val; } ev_t;  // kind 0 addr load, 1 data load, 2 ram write (val = count)
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic [7:0] model_ram [16];
  logic [7:0] bus_ram [16];
  int model_count = 0;
  int model_err = 0;
  logic [3:0] mar_a = 4'h0;
  logic [7:0] mar_d = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shadow of the CPU side: MAR and RAM driven only by what the loader puts on the bus.
  always @(negedge clk) begin
    if (!rst) begin
      int nstb;
      ev_t e;
      nstb = int'(!n_load_addr_o) + int'(!n_load_data_o) + int'(ram_we_o);
      chk("bus_oe_vs_strobe", int'(bus_oe_o), int'(!n_load_addr_o || !n_load_data_o));
      if (nstb > 0) begin
        chk("single_strobe", nstb, 1);
        if (!n_load_addr_o) mar_a = bus_out_o[3:0];
        if (!n_load_data_o) mar_d = bus_out_o;
        if (ram_we_o) bus_ram[mar_a] = mar_d;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", nstb, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", !n_load_addr_o ? 0 : (!n_load_data_o ? 1 : 2), e.kind);
          if (e.kind == 2) chk("count_at_write", int'(load_count_o), e.val);
          else chk("bus_value", int'(bus_out_o), e.val);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) chk("handshake_timeout", int'(in_ready_o), 1);
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input int a, input logic [7:0] d);
    model_count = (model_count + 1 > 16) ? 16 : model_count + 1;
    model_ram[a] = d;
    exp_q.push_back('{0, a});
    exp_q.push_back('{1, int'(d)});
    exp_q.push_back('{2, model_count});
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    send_byte(8'(a));
    send_byte(d);
    wait_drain();
  endtask

  task automatic send_bad(input logic [7:0] a);
    model_err = 1;
    send_byte(a);
    chk("err_after_bad", int'(err_o), 1);
    chk("ready_after_bad", int'(in_ready_o), 1);
  endtask

  task automatic start_session();
    prog_en = 1'b1;
    model_count = 0;
    model_err = 0;
    @(posedge clk);
    #1;
    chk("start_hold", int'(cpu_hold_o), 1);
    chk("start_ready", int'(in_ready_o), 1);
    chk("start_count", int'(load_count_o), 0);
    chk("start_err", int'(err_o), 0);
    chk("start_done", int'(done_o), 0);
  endtask

  task automatic end_with_mark();
    send_byte(8'hFF);
    chk("fin_done", int'(done_o), 1);
    chk("fin_ready", int'(in_ready_o), 0);
    chk("fin_hold", int'(cpu_hold_o), 1);
    chk("fin_count", int'(load_count_o), model_count);
    chk("fin_err", int'(err_o), model_err);
    prog_en = 1'b0;
    @(posedge clk);
    #1;
    chk("release_hold", int'(cpu_hold_o), 0);
    chk("release_done", int'(done_o), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready_o), 0);
    chk({tag, "_bus_out"}, int'(bus_out_o), 0);
    chk({tag, "_bus_oe"}, int'(bus_oe_o), 0);
    chk({tag, "_n_load_addr"}, int'(n_load_addr_o), 1);
    chk({tag, "_n_load_data"}, int'(n_load_data_o), 1);
    chk({tag, "_ram_we"}, int'(ram_we_o), 0);
    chk({tag, "_cpu_hold"}, int'(cpu_hold_o), 0);
    chk({tag, "_load_count"}, int'(load_count_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_err"}, int'(err_o), 0);
  endtask

  initial begin
    int n;
    logic [7:0] a8;
    for (int i = 0; i < 16; i++) begin
      model_ram[i] = 8'h00;
      bus_ram[i] = 8'h00;
    end
    #12;
    chk_reset("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single pair, then end-mark handling.
    start_session();
    send_pair(3, 8'hA5);
    chk("count_one", int'(load_count_o), 1);
    end_with_mark();

    // Saturation at 16 with a rewrite of address 0, then an out-of-range address.
    start_session();
    for (int i = 0; i < 16; i++) send_pair(i, 8'($urandom));
    send_pair(0, 8'($urandom));
    chk("count_sat", int'(load_count_o), 16);
    send_bad(8'h23);
    send_pair(5, 8'h5A);
    chk("count_still_sat", int'(load_count_o), 16);
    end_with_mark();

    // Drop prog_en after only an address byte: nothing written, next session starts fresh.
    start_session();
    send_byte(8'h05);
    prog_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drop_hold", int'(cpu_hold_o), 0);
    chk("drop_ready", int'(in_ready_o), 0);
    start_session();
    send_pair(7, 8'h3C);
    chk("fresh_count", int'(load_count_o), 1);
    end_with_mark();

    // Random session mixing valid pairs and rejected addresses.
    start_session();
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a8 = 8'($urandom_range(16, 254));
        send_bad(a8);
      end else begin
        send_pair($urandom_range(0, 15), 8'($urandom));
      end
    end
    end_with_mark();

    // Asynchronous reset while the data load strobe is active: the write must never happen.
    start_session();
    exp_q.push_back('{0, 9});
    exp_q.push_back('{1, 8'h77});
    send_byte(8'h09);
    send_byte(8'h77);
    n = 0;
    while (n_load_data_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr_data", int'(n_load_data_o), 0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    exp_q.delete();
    prog_en = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_we", int'(ram_we_o), 0);

    for (int i = 0; i < 16; i++) chk($sformatf("ram_%0d", i), int'(bus_ram[i]), int'(model_ram[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
